// File: rtl/intdecl_gen_if.sv
//------------------------------------------------------------------------------
// Module   : intdecl_gen_if
// Brief    : Request and character-stream bundle for intdecl_gen.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface intdecl_gen_if;
  logic       start;
  logic [3:0] num;
  logic       sep_tab;
  logic       kw_first;
  logic [7:0] out_char;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       busy;
  logic       done;

  // The generator is the stream source; the consumer also issues requests.
  modport master (
    input  start, num, sep_tab, kw_first, out_ready,
    output out_char, out_valid, out_last, busy, done
  );

  modport slave (
    output start, num, sep_tab, kw_first, out_ready,
    input  out_char, out_valid, out_last, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/intdecl_gen.sv
//------------------------------------------------------------------------------
// Module   : intdecl_gen
// Brief    : Emits "int<sep>id,id,...;" one character per valid/ready handshake.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module intdecl_gen #(
  parameter logic [7:0] ID_BASE = 8'h61
) (
  input  logic          clk,
  input  logic          reset,
  intdecl_gen_if.master bus
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_KW_I  = 4'd1,
    S_KW_N  = 4'd2,
    S_KW_T  = 4'd3,
    S_SEP   = 4'd4,
    S_ID    = 4'd5,
    S_IDK_I = 4'd6,
    S_IDK_N = 4'd7,
    S_IDK_T = 4'd8,
    S_PUNCT = 4'd9
  } state_t;

  localparam logic [7:0] c_ch_i     = 8'h69;
  localparam logic [7:0] c_ch_n     = 8'h6E;
  localparam logic [7:0] c_ch_t     = 8'h74;
  localparam logic [7:0] c_ch_tab   = 8'h09;
  localparam logic [7:0] c_ch_space = 8'h20;
  localparam logic [7:0] c_ch_comma = 8'h2C;
  localparam logic [7:0] c_ch_semi  = 8'h3B;

  state_t     r_state;
  logic [3:0] r_num;
  logic       r_sep_tab;
  logic       r_kw_first;
  logic [3:0] r_k;
  logic [7:0] r_char;
  logic       r_valid;
  logic       r_last;
  logic       r_busy;
  logic       r_done;

  state_t     w_next_state;
  logic [3:0] w_next_k;
  logic [7:0] w_next_char;
  logic       w_next_last;
  logic       w_hs;
  logic       w_final;

  assign w_hs    = r_valid & bus.out_ready;
  assign w_final = (r_num == 4'd0) || (r_k == r_num - 4'd1);

  always_comb begin
    w_next_state = r_state;
    w_next_k     = r_k;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_next_state = S_KW_I;
          w_next_k     = 4'd0;
        end
      end
      S_KW_I:  if (w_hs) w_next_state = S_KW_N;
      S_KW_N:  if (w_hs) w_next_state = S_KW_T;
      S_KW_T:  if (w_hs) w_next_state = S_SEP;
      S_SEP: begin
        if (w_hs) begin
          if (r_num == 4'd0)   w_next_state = S_PUNCT;
          else if (r_kw_first) w_next_state = S_IDK_I;
          else                 w_next_state = S_ID;
        end
      end
      S_IDK_I: if (w_hs) w_next_state = S_IDK_N;
      S_IDK_N: if (w_hs) w_next_state = S_IDK_T;
      S_IDK_T: if (w_hs) w_next_state = S_PUNCT;
      S_ID:    if (w_hs) w_next_state = S_PUNCT;
      S_PUNCT: begin
        if (w_hs) begin
          if (w_final) begin
            w_next_state = S_IDLE;
          end else begin
            w_next_state = S_ID;
            w_next_k     = r_k + 4'd1;
          end
        end
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // Outputs are precomputed from the next state so they leave the flops directly.
  // PUNCT is only ever entered with k unchanged, so w_final also holds for the next state.
  always_comb begin
    w_next_last = 1'b0;
    unique case (w_next_state)
      S_KW_I, S_IDK_I: w_next_char = c_ch_i;
      S_KW_N, S_IDK_N: w_next_char = c_ch_n;
      S_KW_T, S_IDK_T: w_next_char = c_ch_t;
      S_SEP:           w_next_char = r_sep_tab ? c_ch_tab : c_ch_space;
      S_ID:            w_next_char = ID_BASE + {4'd0, w_next_k};
      S_PUNCT: begin
        w_next_last = w_final;
        w_next_char = w_final ? c_ch_semi : c_ch_comma;
      end
      default:         w_next_char = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_num      <= 4'd0;
      r_sep_tab  <= 1'b0;
      r_kw_first <= 1'b0;
      r_k        <= 4'd0;
      r_char     <= 8'h00;
      r_valid    <= 1'b0;
      r_last     <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state <= w_next_state;
      r_k     <= w_next_k;
      r_char  <= w_next_char;
      r_last  <= w_next_last;
      r_valid <= (w_next_state != S_IDLE);
      r_busy  <= (w_next_state != S_IDLE);
      r_done  <= (r_state == S_PUNCT) && w_hs && w_final;
      if (r_state == S_IDLE && bus.start) begin
        r_num      <= bus.num;
        r_sep_tab  <= bus.sep_tab;
        r_kw_first <= bus.kw_first;
      end
    end
  end

  assign bus.out_char  = r_char;
  assign bus.out_valid = r_valid;
  assign bus.out_last  = r_last;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_intdecl_gen.sv
//------------------------------------------------------------------------------
// Module   : tb_intdecl_gen
// Brief    : Self-checking bench for intdecl_gen against a sentence-level model.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_intdecl_gen;

  localparam logic [7:0] ID_BASE = 8'h61;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  intdecl_gen_if bus();

  intdecl_gen #(.ID_BASE(ID_BASE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [7:0] exp_q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Sentence model: "int", separator, identifier list, ';'.
  task automatic build_exp(input int n, input bit sep, input bit kw);
    exp_q = {};
    exp_q.push_back(8'h69);
    exp_q.push_back(8'h6E);
    exp_q.push_back(8'h74);
    exp_q.push_back(sep ? 8'h09 : 8'h20);
    for (int i = 0; i < n; i++) begin
      if (i > 0) exp_q.push_back(8'h2C);
      if (i == 0 && kw) begin
        exp_q.push_back(8'h69);
        exp_q.push_back(8'h6E);
        exp_q.push_back(8'h74);
      end else begin
        exp_q.push_back(ID_BASE + 8'(i));
      end
    end
    exp_q.push_back(8'h3B);
  endtask

  task automatic launch(input int n, input bit sep, input bit kw);
    bus.num      = 4'(n);
    bus.sep_tab  = sep;
    bus.kw_first = kw;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
    bus.num      = 4'($urandom);
    bus.sep_tab  = 1'($urandom);
    bus.kw_first = 1'($urandom);
    chk("start_busy", 32'(bus.busy), 32'd1);
  endtask

  // mode 0: ready always 1; mode 1: 1,0,0 repeating; mode 2: random
  task automatic consume(input int mode, output int cyc);
    int   idx;
    bit   rdy;
    bit   fin;
    logic [7:0] pc;
    logic       pl;
    idx = 0;
    cyc = 0;
    fin = 0;
    while (!fin && cyc < 400) begin
      rdy = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom);
      bus.out_ready = rdy;
      chk("valid_mid", 32'(bus.out_valid), 32'd1);
      pc = bus.out_char;
      pl = bus.out_last;
      tick();
      cyc++;
      if (rdy) begin
        chk("char", 32'(pc), 32'(exp_q[idx]));
        chk("last", 32'(pl), 32'(idx == exp_q.size() - 1));
        idx++;
        if (idx == exp_q.size()) begin
          chk("done_pulse", 32'(bus.done), 32'd1);
          chk("done_busy", 32'(bus.busy), 32'd0);
          chk("done_valid", 32'(bus.out_valid), 32'd0);
          fin = 1;
        end
      end else begin
        chk("stall_char", 32'(bus.out_char), 32'(exp_q[idx]));
        chk("stall_last", 32'(bus.out_last), 32'(idx == exp_q.size() - 1));
        chk("stall_done", 32'(bus.done), 32'd0);
      end
    end
    if (!fin) chk("timeout", 32'(idx), 32'(exp_q.size()));
    bus.out_ready = 1'b0;
  endtask

  task automatic run(input int n, input bit sep, input bit kw, input int mode);
    int cyc;
    build_exp(n, sep, kw);
    launch(n, sep, kw);
    consume(mode, cyc);
    if (mode == 0) chk("no_bubble", 32'(cyc), 32'(exp_q.size()));
    tick();
    chk("done_once", 32'(bus.done), 32'd0);
    chk("idle_busy", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int cyc;
    bus.start     = 1'b0;
    bus.num       = 4'd0;
    bus.sep_tab   = 1'b0;
    bus.kw_first  = 1'b0;
    bus.out_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_char", 32'(bus.out_char), 32'h00);
    chk("rst_last", 32'(bus.out_last), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    reset = 1'b0;
    tick();

    run(3, 0, 0, 0);
    run(0, 1, 0, 0);
    run(0, 0, 1, 0);
    run(2, 0, 1, 0);
    run(15, 1, 0, 0);
    run(2, 0, 0, 1);
    run(2, 0, 0, 2);

    // Abort a long sentence after four accepted characters.
    launch(15, 0, 0);
    bus.out_ready = 1'b1;
    repeat (4) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bus.out_ready = 1'b0;
    chk("abort_valid", 32'(bus.out_valid), 32'd0);
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    chk("abort_char", 32'(bus.out_char), 32'h00);
    tick();
    chk("abort_nodone", 32'(bus.done), 32'd0);
    run(1, 0, 0, 0);

    // start held high; num changes while the first sentence is in flight.
    build_exp(2, 0, 0);
    bus.num = 4'd2;
    bus.sep_tab = 1'b0;
    bus.kw_first = 1'b0;
    bus.start = 1'b1;
    tick();
    bus.num = 4'd3;
    consume(0, cyc);
    bus.out_ready = 1'b1;
    tick();
    chk("restart_valid", 32'(bus.out_valid), 32'd1);
    chk("restart_char", 32'(bus.out_char), 32'h69);
    chk("restart_done", 32'(bus.done), 32'd0);
    bus.start = 1'b0;
    build_exp(3, 0, 0);
    consume(0, cyc);
    chk("restart_len", 32'(cyc), 32'd10);
    tick();

    for (int t = 0; t < 25; t++) begin
      run(int'($urandom_range(0, 15)), 1'($urandom), 1'($urandom), int'($urandom_range(0, 2)));
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/intdecl_gen.md
# intdecl_gen

Character-stream generator for the declaration-checker path. On a start pulse it emits one ASCII character per accepted handshake, forming a C-style integer declaration: `int`, one separator, then a comma-separated identifier list terminated by `;`. It sits upstream of the declaration checker and drives it with positive and negative sentences. It supports consumer backpressure via a valid/ready handshake.

## Interface
- `ID_BASE`, default 8'h61 ("a"): ASCII code of identifier 0; identifier k is `ID_BASE+k`.
- `clk` input, 1 bit: clock; all state changes on the rising edge.
- `reset` input, 1 bit: reset is synchronous, active-high; clock is `clk`.
- `start` input, 1 bit: request a sentence; sampled only in IDLE.
- `num` input, 4 bits: identifier count, 0..15; latched on accepted start.
- `sep_tab` input, 1 bit: separator after `int`; 1 = tab (8'h09), 0 = space (8'h20); latched on accepted start.
- `kw_first` input, 1 bit: 1 = identifier 0 is emitted as the three characters `int` (illegal sentence); latched on accepted start. Ignored when num=0.
- `out_char` output, 8 bits: current character; held stable while stalled.
- `out_valid` output, 1 bit: `out_char` is valid.
- `out_ready` input, 1 bit: consumer accepts `out_char` when high together with `out_valid`.
- `out_last` output, 1 bit: high with the terminating `;`.
- `busy` output, 1 bit: high in any state other than IDLE.
- `done` output, 1 bit: one-cycle pulse after `;` is accepted.

## Operation
- States: IDLE, KW_I, KW_N, KW_T, SEP, ID, IDK_I, IDK_N, IDK_T, PUNCT.
- A handshake (hs) is a cycle with `out_valid` and `out_ready` both high. A state advances only on hs; otherwise it holds with all outputs unchanged.
- IDLE:
  - `out_valid` is 0.
  - start=1 latches `num`, `sep_tab` and `kw_first`, clears the 4-bit index k, and moves to KW_I.
  - start in any other state is ignored.
- KW_I emits "i" and goes to KW_N. KW_N emits "n" and goes to KW_T. KW_T emits "t" and goes to SEP.
- SEP emits the tab or space character. Next state:
  - num=0: PUNCT.
  - kw_first=1: IDK_I.
  - otherwise: ID.
- IDK_I, IDK_N and IDK_T emit "i", "n" and "t". IDK_T goes to PUNCT.
- ID emits `ID_BASE+k` (8-bit add, wraps modulo 256) and goes to PUNCT.
- PUNCT:
  - num=0 or k=num-1: emits ";" with `out_last`=1; on hs goes to IDLE and pulses `done`.
  - otherwise: emits ","; on hs increments k and goes to ID.
- Sentence length is 5 characters for num=0, 4+2·num for kw_first=0, and 6+2·num for kw_first=1.
- k never wraps, because num ≤ 15.
- Reset:
  - At reset, or at any point mid-sentence: next edge goes to IDLE.
  - Values after reset: `out_valid`=0, `out_char`=8'h00, `out_last`=0, `busy`=0, `done`=0, k=0.
  - The partial sentence is abandoned; no `done` pulse is produced.
- Latched config is not affected by input changes while busy.

## Timing
- All outputs are registered.
- Start accepted at edge E: at edge E+1, `out_valid`=1, `out_char`="i", and `busy`=1.
- With `out_ready` held at 1, one character is issued per cycle with no bubbles.
- When `;` is accepted at edge F:
  - At edge F+1, `done`=1 for exactly one cycle, while `busy`=0 and `out_valid`=0.
  - `start` sampled at edge F+1 is accepted; the next "i" is valid at edge F+2. Minimum inter-sentence gap is one idle cycle.
- Stall: while `out_ready`=0, `out_char`, `out_valid` and `out_last` hold. There is no combinational path from `out_ready` to any output.
- `out_valid` is never deasserted mid-sentence except by reset.

## Test plan
- num=3, sep_tab=0, kw_first=0, `out_ready`=1: "int a,b,c;" (69 6E 74 20 61 2C 62 2C 63 3B) over 10 consecutive cycles; `out_last` only on 3B; `done` pulses the next cycle.
- num=0, sep_tab=1: "int\t;" (69 6E 74 09 3B), 5 characters.
- num=2, kw_first=1, sep_tab=0: "int int,b;" (10 characters).
- num=2 with `out_ready` toggling 1,0,0,1,… or random: each character is held stable while stalled; no character is lost or duplicated; the accepted sequence equals "int a,b;".
- Assert reset after the 4th hs of a num=15 sentence: next cycle `out_valid`=0, `busy`=0, and no `done`. A new start with num=1 yields "int a;".
- start=1 held continuously with num changed mid-sentence: the first sentence uses the latched num. A second sentence begins exactly 2 cycles after the first `;` hs and uses the num present at its start.
